mem_stage_gen: RTL and testbench

Parametrised successor to the single-cycle memory stage. It holds the EX/MEM pipeline register with flush and stall support, and a byte-addressable data memory of configurable depth. Byte, halfword and word loads and stores are supported, with sign or zero extension on loads. A wait-state FSM models memory latency and drives a stall back to the hazard unit. It sits between the execute stage and the MEM/WB register.

---
 rtl/mem_stage_pkg.sv | 8 +
 rtl/data_mem_be.sv | 18 +
 rtl/mem_stage_gen.sv | 83 ++++++++
 tb/tb_mem_stage_gen.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: size encodings, wait-state FSM states and counter width for the memory stage.
package mem_stage_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam int CNT_W = 4;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} memState_t;
endpackage

// File: rtl/data_mem_be.sv
// data_mem_be: word-organised data memory with per-byte write enables, combinational read and async clear.
module data_mem_be #(
  parameter int AW = 8
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);
  logic [31:0] mem [2**AW];
  always_ff @(posedge CLK or negedge rst)
    if (!rst) for (int i = 0; i < 2**AW; i++) mem[i] <= '0;
    else if (we) for (int b = 0; b < 4; b++) if (be[b]) mem[addr][8*b +: 8] <= wd[8*b +: 8];
  assign rd = mem[addr];
endmodule

// File: rtl/mem_stage_gen.sv
// mem_stage_gen: EX/MEM register, byte-enable data memory and wait-state FSM; MEM_MISALIGN_EN enables misalignment trapping.
module mem_stage_gen
  import mem_stage_pkg::*;
#(
  parameter int AW = 8,
  parameter int WAIT_CYC = 0
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [31:0] ALUOutE,
  input  logic [31:0] WriteDataE,
  input  logic        MemWriteE,
  input  logic        MemReadE,
  input  logic        RegWriteE,
  input  logic        MemtoRegE,
  input  logic [1:0]  SizeE,
  input  logic        UnsignedE,
  input  logic [4:0]  WriteRegE,
  input  logic        FlushM,
  output logic        RegWriteM,
  output logic        MemtoRegM,
  output logic [31:0] ALUOutM,
  output logic [4:0]  WriteRegM,
  output logic [31:0] RD,
  output logic        StallM,
  output logic        MisalignM
);
  localparam logic [CNT_W-1:0] NW = CNT_W'(WAIT_CYC);
  memState_t state;
  logic [CNT_W-1:0] cnt;
  logic memWriteM, memReadM, unsignedM, misE, waitE, isWord, isHalf, we;
  logic [1:0] sizeM;
  logic [31:0] writeDataM, rdWord, wd;
  logic [3:0] be;
  logic [7:0] byteV;
  logic [15:0] halfV;
`ifdef MEM_MISALIGN_EN
  assign misE = !FlushM && ((SizeE == SZ_HALF && ALUOutE[0]) || (SizeE[1] && |ALUOutE[1:0]));
`else
  assign misE = 1'b0;
`endif
  assign waitE = !FlushM && (MemWriteE || MemReadE) && !misE && WAIT_CYC > 0;
  assign StallM = state == WAIT;
  always_ff @(posedge CLK or negedge rst)
    if (!rst) begin
      {RegWriteM, MemtoRegM, memWriteM, memReadM, unsignedM, MisalignM} <= '0;
      ALUOutM <= '0;
      WriteRegM <= '0;
      writeDataM <= '0;
      sizeM <= '0;
      state <= IDLE;
      cnt <= '0;
    end else if (!StallM) begin
      RegWriteM <= !FlushM && RegWriteE;
      MemtoRegM <= !FlushM && MemtoRegE;
      memWriteM <= !FlushM && MemWriteE;
      memReadM <= !FlushM && MemReadE;
      unsignedM <= !FlushM && UnsignedE;
      MisalignM <= misE;
      ALUOutM <= FlushM ? '0 : ALUOutE;
      WriteRegM <= FlushM ? '0 : WriteRegE;
      writeDataM <= FlushM ? '0 : WriteDataE;
      sizeM <= FlushM ? '0 : SizeE;
      state <= waitE ? WAIT : IDLE;
      cnt <= waitE ? NW : '0;
    end else begin
      cnt <= cnt - 1'b1;
      state <= cnt == CNT_W'(1) ? DONE : WAIT;
    end
  // SizeE=11 decodes as a word access alongside 10
  assign isWord = sizeM[1];
  assign isHalf = sizeM == SZ_HALF;
  assign be = isWord ? 4'hF : isHalf ? (ALUOutM[1] ? 4'hC : 4'h3) : 4'b0001 << ALUOutM[1:0];
  assign wd = isWord ? writeDataM : isHalf ? {2{writeDataM[15:0]}} : {4{writeDataM[7:0]}};
  assign we = memWriteM && !StallM && !MisalignM;
  data_mem_be #(.AW(AW)) uMem (
    .CLK(CLK), .rst(rst), .we(we), .be(be), .addr(ALUOutM[AW+1:2]), .wd(wd), .rd(rdWord)
  );
  assign byteV = rdWord[{ALUOutM[1:0], 3'b000} +: 8];
  assign halfV = rdWord[{ALUOutM[1], 4'b0000} +: 16];
  assign RD = MisalignM ? '0 : isWord ? rdWord :
              isHalf ? {{16{!unsignedM && halfV[15]}}, halfV} : {{24{!unsignedM && byteV[7]}}, byteV};
endmodule

// File: tb/tb_mem_stage_gen.sv
// tb_mem_stage_gen: directed checks on a zero-wait and a three-wait instance sharing one stimulus bus.
module tb_mem_stage_gen;
  logic CLK = 1'b0, rst = 1'b0;
  logic [31:0] ALUOutE = '0, WriteDataE = '0;
  logic MemWriteE = 0, MemReadE = 0, RegWriteE = 0, MemtoRegE = 0, UnsignedE = 0, FlushM = 0;
  logic [1:0] SizeE = '0;
  logic [4:0] WriteRegE = '0;
  logic regWriteM0, memtoRegM0, stallM0, misalignM0, regWriteM3, memtoRegM3, stallM3, misalignM3;
  logic [31:0] aluOutM0, rd0, aluOutM3, rd3;
  logic [4:0] writeRegM0, writeRegM3;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  mem_stage_gen #(.AW(8), .WAIT_CYC(0)) dut0 (
    .CLK(CLK), .rst(rst), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .MemWriteE(MemWriteE),
    .MemReadE(MemReadE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .SizeE(SizeE),
    .UnsignedE(UnsignedE), .WriteRegE(WriteRegE), .FlushM(FlushM), .RegWriteM(regWriteM0),
    .MemtoRegM(memtoRegM0), .ALUOutM(aluOutM0), .WriteRegM(writeRegM0), .RD(rd0),
    .StallM(stallM0), .MisalignM(misalignM0));

  mem_stage_gen #(.AW(8), .WAIT_CYC(3)) dut3 (
    .CLK(CLK), .rst(rst), .ALUOutE(ALUOutE), .WriteDataE(WriteDataE), .MemWriteE(MemWriteE),
    .MemReadE(MemReadE), .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .SizeE(SizeE),
    .UnsignedE(UnsignedE), .WriteRegE(WriteRegE), .FlushM(FlushM), .RegWriteM(regWriteM3),
    .MemtoRegM(memtoRegM3), .ALUOutM(aluOutM3), .WriteRegM(writeRegM3), .RD(rd3),
    .StallM(stallM3), .MisalignM(misalignM3));

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic setOp(input logic w, input logic r, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data, input logic [4:0] wr,
                       input logic fl);
    MemWriteE = w; MemReadE = r; RegWriteE = r; MemtoRegE = r; SizeE = sz; UnsignedE = uns;
    ALUOutE = addr; WriteDataE = data; WriteRegE = wr; FlushM = fl;
  endtask

  task automatic test_reset();
    rst = 0;
    setOp(1, 1, 2'b10, 0, 32'h10, 32'h1, 5'd4, 0);
    step(); step();
    checks++; if ({regWriteM0, memtoRegM0, stallM0, misalignM0} !== 4'b0) begin errors++; $display("FAIL reset_ctl0 got %b exp 0000", {regWriteM0, memtoRegM0, stallM0, misalignM0}); end
    checks++; if ({regWriteM3, memtoRegM3, stallM3, misalignM3} !== 4'b0) begin errors++; $display("FAIL reset_ctl3 got %b exp 0000", {regWriteM3, memtoRegM3, stallM3, misalignM3}); end
    checks++; if (aluOutM0 !== 32'h0 || writeRegM0 !== 5'd0) begin errors++; $display("FAIL reset_data0 got %h/%h exp 0/0", aluOutM0, writeRegM0); end
    checks++; if (rd3 !== 32'h0) begin errors++; $display("FAIL reset_rd3 got %h exp 0", rd3); end
    setOp(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
    rst = 1;
  endtask

  task automatic test_word();
    setOp(1, 0, 2'b10, 0, 32'h10, 32'hDEADBEEF, 5'd0, 0);
    step();
    checks++; if (stallM0 !== 1'b0) begin errors++; $display("FAIL word_store_stall got %b exp 0", stallM0); end
    setOp(0, 1, 2'b10, 0, 32'h10, 32'h0, 5'd6, 0);
    step();
    checks++; if (rd0 !== 32'hDEADBEEF) begin errors++; $display("FAIL word_load got %h exp deadbeef", rd0); end
    checks++; if (aluOutM0 !== 32'h10 || writeRegM0 !== 5'd6 || memtoRegM0 !== 1'b1) begin errors++; $display("FAIL word_mreg got %h/%h/%b exp 10/06/1", aluOutM0, writeRegM0, memtoRegM0); end
  endtask

  task automatic test_byte_half();
    setOp(1, 0, 2'b00, 0, 32'h13, 32'h00000080, 5'd0, 0);
    step();
    setOp(0, 1, 2'b00, 0, 32'h13, 32'h0, 5'd1, 0);
    step();
    checks++; if (rd0 !== 32'hFFFFFF80) begin errors++; $display("FAIL byte_signed got %h exp ffffff80", rd0); end
    setOp(0, 1, 2'b00, 1, 32'h13, 32'h0, 5'd1, 0);
    step();
    checks++; if (rd0 !== 32'h00000080) begin errors++; $display("FAIL byte_unsigned got %h exp 00000080", rd0); end
    setOp(0, 1, 2'b11, 0, 32'h10, 32'h0, 5'd1, 0);
    step();
    checks++; if (rd0 !== 32'h80ADBEEF) begin errors++; $display("FAIL byte_others got %h exp 80adbeef", rd0); end
    setOp(0, 1, 2'b01, 0, 32'h12, 32'h0, 5'd1, 0);
    step();
    checks++; if (rd0 !== 32'hFFFF80AD) begin errors++; $display("FAIL half_signed got %h exp ffff80ad", rd0); end
    setOp(0, 1, 2'b01, 1, 32'h10, 32'h0, 5'd1, 0);
    step();
    checks++; if (rd0 !== 32'h0000BEEF) begin errors++; $display("FAIL half_unsigned got %h exp 0000beef", rd0); end
    setOp(0, 1, 2'b00, 0, 32'h11, 32'h0, 5'd1, 0);
    step();
    checks++; if (rd0 !== 32'hFFFFFFBE) begin errors++; $display("FAIL byte_lane1 got %h exp ffffffbe", rd0); end
  endtask

  task automatic test_flush_wrap();
    setOp(1, 0, 2'b10, 0, 32'h10, 32'h11111111, 5'd7, 1);
    RegWriteE = 1; MemtoRegE = 1;
    step();
    checks++; if ({regWriteM0, memtoRegM0} !== 2'b00 || writeRegM0 !== 5'd0 || aluOutM0 !== 32'h0) begin errors++; $display("FAIL flush_bubble got %b/%h/%h exp 00/00/0", {regWriteM0, memtoRegM0}, writeRegM0, aluOutM0); end
    setOp(0, 1, 2'b10, 0, 32'h10, 32'h0, 5'd1, 0);
    step();
    checks++; if (rd0 !== 32'h80ADBEEF) begin errors++; $display("FAIL flush_nowrite got %h exp 80adbeef", rd0); end
    setOp(1, 0, 2'b10, 0, 32'h410, 32'h12345678, 5'd0, 0);
    step();
    setOp(0, 1, 2'b10, 0, 32'h10, 32'h0, 5'd1, 0);
    step();
    checks++; if (rd0 !== 32'h12345678) begin errors++; $display("FAIL addr_wrap got %h exp 12345678", rd0); end
  endtask

  task automatic test_misalign0();
    setOp(1, 0, 2'b01, 0, 32'h21, 32'h0000ABCD, 5'd0, 0);
    step();
`ifdef MEM_MISALIGN_EN
    checks++; if (misalignM0 !== 1'b1) begin errors++; $display("FAIL mis0_flag got %b exp 1", misalignM0); end
`else
    checks++; if (misalignM0 !== 1'b0) begin errors++; $display("FAIL mis0_flag got %b exp 0", misalignM0); end
`endif
    setOp(0, 1, 2'b10, 0, 32'h20, 32'h0, 5'd1, 0);
    step();
`ifdef MEM_MISALIGN_EN
    checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL mis0_mem got %h exp 00000000", rd0); end
`else
    checks++; if (rd0 !== 32'h0000ABCD) begin errors++; $display("FAIL mis0_mem got %h exp 0000abcd", rd0); end
`endif
    setOp(0, 1, 2'b01, 0, 32'h21, 32'h0, 5'd1, 0);
    step();
`ifdef MEM_MISALIGN_EN
    checks++; if (rd0 !== 32'h0 || misalignM0 !== 1'b1) begin errors++; $display("FAIL mis0_load got %h/%b exp 0/1", rd0, misalignM0); end
`else
    checks++; if (rd0 !== 32'hFFFFABCD || misalignM0 !== 1'b0) begin errors++; $display("FAIL mis0_load got %h/%b exp ffffabcd/0", rd0, misalignM0); end
`endif
  endtask

  task automatic test_wait();
    rst = 0; #2; rst = 1;
    setOp(0, 0, 2'b00, 0, 32'h5, 32'h0, 5'd2, 0);
    RegWriteE = 1;
    step();
    checks++; if (stallM3 !== 1'b0 || regWriteM3 !== 1'b1) begin errors++; $display("FAIL wait_alu_nostall got %b/%b exp 0/1", stallM3, regWriteM3); end
    setOp(1, 0, 2'b10, 0, 32'h40, 32'hCAFEF00D, 5'd3, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (stallM3 !== 1'b1 || aluOutM3 !== 32'h40 || writeRegM3 !== 5'd3) begin errors++; $display("FAIL wait_store_hold%0d got %b/%h/%h exp 1/40/03", i, stallM3, aluOutM3, writeRegM3); end
      setOp(0, 1, 2'b00, 1, 32'h999, 32'h0, 5'd31, i == 1);
      step();
    end
    checks++; if (stallM3 !== 1'b0 || aluOutM3 !== 32'h40) begin errors++; $display("FAIL wait_store_done got %b/%h exp 0/40", stallM3, aluOutM3); end
    setOp(0, 1, 2'b10, 0, 32'h40, 32'h0, 5'd5, 0);
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if (stallM3 !== 1'b1 || writeRegM3 !== 5'd5 || memtoRegM3 !== 1'b1) begin errors++; $display("FAIL wait_load_hold%0d got %b/%h/%b exp 1/05/1", i, stallM3, writeRegM3, memtoRegM3); end
      setOp(1, 0, 2'b00, 0, 32'h7, 32'hFF, 5'd30, i == 0);
      step();
    end
    checks++; if (stallM3 !== 1'b0 || rd3 !== 32'hCAFEF00D) begin errors++; $display("FAIL wait_load_rd got %b/%h exp 0/cafef00d", stallM3, rd3); end
  endtask

  task automatic test_reset_mid();
    setOp(1, 0, 2'b10, 0, 32'h44, 32'h55AA55AA, 5'd0, 0);
    step();
    step();
    #2 rst = 0;
    #1;
    checks++; if (stallM3 !== 1'b0 || aluOutM3 !== 32'h0) begin errors++; $display("FAIL rstmid_async got %b/%h exp 0/0", stallM3, aluOutM3); end
    setOp(0, 0, 2'b00, 0, 32'h0, 32'h0, 5'd0, 0);
    @(negedge CLK) rst = 1;
    step();
    checks++; if (stallM3 !== 1'b0) begin errors++; $display("FAIL rstmid_idle got %b exp 0", stallM3); end
    setOp(0, 1, 2'b10, 0, 32'h44, 32'h0, 5'd1, 0);
    step();
    checks++; if (stallM3 !== 1'b1) begin errors++; $display("FAIL rstmid_load_stall got %b exp 1", stallM3); end
    repeat (3) step();
    checks++; if (stallM3 !== 1'b0 || rd3 !== 32'h0) begin errors++; $display("FAIL rstmid_dropped got %b/%h exp 0/0", stallM3, rd3); end
  endtask

  task automatic test_misalign3();
    setOp(1, 0, 2'b01, 0, 32'h21, 32'h0000ABCD, 5'd0, 0);
    step();
`ifdef MEM_MISALIGN_EN
    checks++; if (stallM3 !== 1'b0 || misalignM3 !== 1'b1) begin errors++; $display("FAIL mis3_nostall got %b/%b exp 0/1", stallM3, misalignM3); end
    setOp(0, 1, 2'b10, 0, 32'h20, 32'h0, 5'd1, 0);
    repeat (4) step();
    checks++; if (stallM3 !== 1'b0 || rd3 !== 32'h0) begin errors++; $display("FAIL mis3_mem got %b/%h exp 0/0", stallM3, rd3); end
`else
    checks++; if (stallM3 !== 1'b1 || misalignM3 !== 1'b0) begin errors++; $display("FAIL mis3_stall got %b/%b exp 1/0", stallM3, misalignM3); end
    setOp(0, 1, 2'b10, 0, 32'h20, 32'h0, 5'd1, 0);
    repeat (7) step();
    checks++; if (stallM3 !== 1'b0 || rd3 !== 32'h0000ABCD) begin errors++; $display("FAIL mis3_mem got %b/%h exp 0/0000abcd", stallM3, rd3); end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte_half();
    test_flush_wrap();
    test_misalign0();
    test_wait();
    test_reset_mid();
    test_misalign3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
